result_checker: RTL
===================

Name: result_checker

Overview:
- Compares the DUT result stream against the golden-model result stream.
- Emits a one-cycle mismatch pulse that drives the downstream event counter's i_event input.
- Buffers golden results in an internal FIFO, because the golden model normally produces results ahead of the DUT.
- Captures the first failing pair for debug readout.

Parameters:
- WIDTH, 32, data width of golden and DUT results.
- DEPTH, 16, golden FIFO depth in entries; must be a power of 2, at least 2.
- TOL, 0, maximum allowed absolute difference; used only when CHECKER_TOLERANCE_EN is defined.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- i_ref_valid  input  1  golden result valid this cycle.
- i_ref_data  input  WIDTH  golden result.
- i_dut_valid  input  1  DUT result valid this cycle.
- i_dut_data  input  WIDTH  DUT result.
- o_event  output  1  one-cycle pulse on mismatch or orphan DUT result.
- o_cmp_valid  output  1  one-cycle pulse per completed comparison.
- o_overflow  output  1  sticky flag: a golden result was dropped.
- o_fill  output  $clog2(DEPTH)+1  current FIFO occupancy.
- o_first_valid  output  1  first-failure capture is held.
- o_first_exp  output  WIDTH  expected value of first failure.
- o_first_got  output  WIDTH  DUT value of first failure.

Behaviour:
- Reset, clk and reset: reset is asynchronous, active-high; clock is clk. Reset values:
  - all outputs 0;
  - FIFO empty (rd/wr pointers 0, o_fill 0);
  - capture FSM in ARMED.
  - Reset mid-stream discards all buffered entries; no pulse is generated in the reset cycle or the following one.
- Push: i_ref_valid with FIFO not full writes i_ref_data at the tail.
- Push overflow: i_ref_valid with FIFO full and no simultaneous pop drops the data and sets o_overflow. o_overflow stays set until reset.
- Pop/compare: i_dut_valid pops the head and compares it with i_dut_data.
  - Registered result: o_cmp_valid=1 on the next cycle (latency 1).
  - o_event=1 on that same cycle if the values differ.
- Bypass: FIFO empty with i_ref_valid and i_dut_valid in the same cycle compares i_ref_data against i_dut_data directly. Nothing is stored; o_fill stays 0.
- Orphan: i_dut_valid with FIFO empty and no i_ref_valid:
  - o_event=1 next cycle, o_cmp_valid=0;
  - treated as a failure with expected value 0.
- Full + push + pop same cycle: both happen, o_fill unchanged, no overflow.
- Pointers: log2(DEPTH) bits, wrap naturally. o_fill = pushes − pops, range 0..DEPTH.
- Capture FSM, two states:
  - ARMED: on the first failure (mismatch or orphan), latch o_first_exp/o_first_got, set o_first_valid. Takes effect in the same registered cycle as o_event. Move to CAPTURED.
  - CAPTURED: holds the captured values; later failures still pulse o_event but do not update the capture. Leaves only on reset.
- Back-to-back: one comparison per cycle, full throughput; o_event may be high on consecutive cycles.
- Unsigned comparison throughout.

Optional Feature:
- Macro: CHECKER_TOLERANCE_EN.
- Defined: a comparison passes when |exp − got| ≤ TOL. The difference is computed in WIDTH+1 bits, unsigned, as max − min. Orphans always fail.
- Undefined: exact equality only; TOL is ignored and no subtractor is synthesised.

Test Plan:
- Matching stream: push 0x10,0x20,0x30 at cycles 1-3; DUT gives the same values at cycles 5-7 -> o_cmp_valid pulses at cycles 6-8, o_event stays 0, o_fill returns to 0.
- Mismatch: push 0xA5; DUT gives 0xA4 -> o_event=1 one cycle after DUT valid, o_first_valid=1, o_first_exp=0xA5, o_first_got=0xA4. A second mismatch (0x01 vs 0x02) pulses o_event; the capture is unchanged.
- Overflow and full edge: push 17 values with DEPTH=16 and no pops -> o_fill=16, o_overflow=1. Then push and pop together -> o_fill stays 16.
- Orphan and bypass:
  - DUT valid 0x55 with FIFO empty -> o_event=1, o_cmp_valid=0, capture exp=0, got=0x55.
  - After reset, both valid with 0x7 at once on an empty FIFO -> o_cmp_valid=1, o_event=0, o_fill=0.
- Reset mid-stream: push 5 entries, assert reset for 1 cycle -> o_fill=0, o_overflow=0, o_first_valid=0. A following DUT valid is treated as an orphan.
- Tolerance (CHECKER_TOLERANCE_EN, TOL=2):
  - exp 100 vs got 102 -> no event;
  - exp 100 vs got 97 -> event;
  - exp 0 vs got 0xFFFFFFFF -> event (no wrap).

Source files
------------

// File: rtl/result_checker.sv
// -----------------------------------------------------------------------------
// result_checker
//
// Compares a DUT result stream against a golden-model result stream. Golden
// results are buffered in a FIFO because the golden model normally runs ahead
// of the DUT. Each DUT result pops one golden entry and compares against it.
// The registered result appears one cycle later:
//   - o_cmp_valid pulses once per completed comparison.
//   - o_event pulses on a mismatch, or on an orphan DUT result.
// The first failing pair is captured for debug readout.
//
// Optional feature (macro CHECKER_TOLERANCE_EN):
//   - defined   : a comparison passes when |exp - got| <= TOL.
//   - undefined : exact equality only; TOL is ignored.
//
// Parameters:
//   WIDTH  data width of golden and DUT results
//   DEPTH  golden FIFO depth, a power of 2 that is at least 2
//   TOL    maximum allowed absolute difference (tolerance build only)
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   i_ref_valid/data golden result stream
//   i_dut_valid/data DUT result stream
//   o_event          one-cycle pulse on mismatch or orphan DUT result
//   o_cmp_valid      one-cycle pulse per completed comparison
//   o_overflow       sticky: a golden result was dropped because the FIFO was full
//   o_fill           current FIFO occupancy, 0..DEPTH
//   o_first_valid    a first-failure capture is held
//   o_first_exp/got  expected and DUT values of the first failure
// -----------------------------------------------------------------------------
module result_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int TOL   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_ref_valid,
  input  logic [WIDTH-1:0]         i_ref_data,
  input  logic                     i_dut_valid,
  input  logic [WIDTH-1:0]         i_dut_data,
  output logic                     o_event,
  output logic                     o_cmp_valid,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_fill,
  output logic                     o_first_valid,
  output logic [WIDTH-1:0]         o_first_exp,
  output logic [WIDTH-1:0]         o_first_got
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [0:0] ST_ARMED    = 1'b0;
  localparam logic [0:0] ST_CAPTURED = 1'b1;

  // Reject parameter sets the pointer arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TOL < 0) begin : g_param_check
    $error("result_checker: DEPTH must be a power of 2 >= 2 and TOL >= 0");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             event_q, event_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic             overflow_q, overflow_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic             fifo_empty;
  logic             fifo_full;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             drop;
  logic             orphan;
  logic             cmp_do;
  logic [WIDTH-1:0] cmp_exp;
  logic             cmp_pass;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    // An empty FIFO with both streams valid compares directly; nothing is stored.
    bypass     = fifo_empty & i_ref_valid & i_dut_valid;
    pop        = i_dut_valid & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push       = i_ref_valid & ~bypass & (~fifo_full | pop);
    drop       = i_ref_valid & fifo_full & ~pop;
    orphan     = i_dut_valid & fifo_empty & ~i_ref_valid;
    cmp_do     = pop | bypass;
    cmp_exp    = bypass ? i_ref_data : mem_q[rd_ptr_q];
  end

`ifdef CHECKER_TOLERANCE_EN
  // One extra bit so max - min never wraps.
  logic [WIDTH:0] abs_diff;

  always_comb begin
    if (cmp_exp >= i_dut_data) begin
      abs_diff = {1'b0, cmp_exp} - {1'b0, i_dut_data};
    end else begin
      abs_diff = {1'b0, i_dut_data} - {1'b0, cmp_exp};
    end
    cmp_pass = (abs_diff <= (WIDTH+1)'(TOL));
  end
`else
  always_comb begin
    cmp_pass = (cmp_exp == i_dut_data);
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default at the top of the block; a path that
    // skips an assignment would otherwise infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;

    // Pointers are exactly AW bits wide, so they wrap naturally at DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    cmp_valid_d = cmp_do;
    event_d     = orphan | (cmp_do & ~cmp_pass);
    overflow_d  = overflow_q | drop;

    // The capture lands in the same registered cycle as the o_event it explains.
    // An orphan has no golden value, so its expected value is recorded as 0.
    if (state_q == ST_ARMED && event_d) begin
      state_d     = ST_CAPTURED;
      first_exp_d = orphan ? '0 : cmp_exp;
      first_got_d = i_dut_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      event_q     <= 1'b0;
      cmp_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= ST_ARMED;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      event_q     <= event_d;
      cmp_valid_q <= cmp_valid_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  // NOTE: the storage array has no reset. Entries are only read after being
  // written, and resetting the pointers is enough to discard old contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_ref_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_event       = event_q;
  assign o_cmp_valid   = cmp_valid_q;
  assign o_overflow    = overflow_q;
  assign o_fill        = count_q;
  assign o_first_valid = (state_q == ST_CAPTURED);
  assign o_first_exp   = first_exp_q;
  assign o_first_got   = first_got_q;

endmodule
